// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-port word memory between the fetch port and
//               the load/store port. Round-robin grant, req/ready handshake,
//               read-modify-write for sub-word stores, load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_last_d;      // 1 when the data port holds the last grant
    logic        r_gnt_d;
    logic        r_we;
    logic        r_unsigned;
    logic        r_err;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [31:0] r_rd_word;

    logic        w_any_req;
    logic        w_grant_d;
    logic [31:0] w_addr;
    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_misalign;
    logic        w_req_err;
    logic [31:0] w_merged;
    logic [31:0] w_load_val;

    // Grant selection and request error checking for the port being granted
    always_comb begin
        w_any_req  = i_req | d_req;
        w_grant_d  = d_req & (~i_req | ~r_last_d);
        w_addr     = w_grant_d ? d_addr : i_addr;
        w_offset   = w_addr - STARTING_ADDR;
        w_in_range = (w_addr >= STARTING_ADDR) && (w_offset < MEM_DEPTH_BYTES);
        w_misalign = 1'b0;
        if (w_grant_d) begin
            case (d_size)
                2'd1:    w_misalign = w_addr[0];
                2'd2:    w_misalign = |w_addr[1:0];
                default: w_misalign = 1'b0;
            endcase
        end else begin
            w_misalign = |w_addr[1:0];
        end
        w_req_err = ~w_in_range | w_misalign | (w_grant_d & (d_size == 2'd3));
    end

    // Store merge: replace only the addressed lanes of the word just read
    always_comb begin
        w_merged = mem_data_out;
        case (r_size)
            2'd0:    w_merged[{r_lane, 3'b000} +: 8]        = r_wdata[7:0];
            2'd1:    w_merged[{r_lane[1], 4'b0000} +: 16]   = r_wdata[15:0];
            default: w_merged                               = r_wdata;
        endcase
    end

    // Load extraction and sign/zero extension from the captured word
    always_comb begin
        w_load_val = r_rd_word;
        case (r_size)
            2'd0: begin
                w_load_val[7:0]  = r_rd_word[{r_lane, 3'b000} +: 8];
                w_load_val[31:8] = {24{~r_unsigned & w_load_val[7]}};
            end
            2'd1: begin
                w_load_val[15:0]  = r_rd_word[{r_lane[1], 4'b0000} +: 16];
                w_load_val[31:16] = {16{~r_unsigned & w_load_val[15]}};
            end
            default: w_load_val = r_rd_word;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next_state = w_req_err ? S_RESP : S_ACCESS;
            S_ACCESS: w_next_state = (r_gnt_d & r_we) ? S_WRITE : S_RESP;
            S_WRITE:  w_next_state = S_RESP;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Transaction latch, memory port drive and registered responses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_d       <= 1'b1;
            r_gnt_d        <= 1'b0;
            r_we           <= 1'b0;
            r_unsigned     <= 1'b0;
            r_err          <= 1'b0;
            r_size         <= 2'd0;
            r_lane         <= 2'd0;
            r_wdata        <= 32'd0;
            r_rd_word      <= 32'd0;
            i_ready        <= 1'b0;
            i_rdata        <= 32'd0;
            i_err          <= 1'b0;
            d_ready        <= 1'b0;
            d_rdata        <= 32'd0;
            d_err          <= 1'b0;
            mem_address    <= STARTING_ADDR;
            mem_data_in    <= 32'd0;
            mem_read_write <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            i_rdata <= 32'd0;
            i_err   <= 1'b0;
            d_ready <= 1'b0;
            d_rdata <= 32'd0;
            d_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last_d   <= w_grant_d;
                        r_gnt_d    <= w_grant_d;
                        r_we       <= w_grant_d & d_we;
                        r_size     <= w_grant_d ? d_size : 2'd2;
                        r_unsigned <= d_unsigned;
                        r_lane     <= w_addr[1:0];
                        r_wdata    <= d_wdata;
                        r_err      <= w_req_err;
                        if (!w_req_err) begin
                            mem_address    <= {w_addr[31:2], 2'b00};
                            mem_read_write <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_rd_word <= mem_data_out;
                    if (r_gnt_d && r_we) begin
                        mem_read_write <= 1'b1;
                        mem_data_in    <= w_merged;
                    end
                end
                S_WRITE: begin
                    mem_read_write <= 1'b0;
                end
                default: begin
                    if (r_gnt_d) begin
                        d_ready <= 1'b1;
                        d_err   <= r_err;
                        d_rdata <= (r_err || r_we) ? 32'd0 : w_load_val;
                    end else begin
                        i_ready <= 1'b1;
                        i_err   <= r_err;
                        i_rdata <= r_err ? 32'd0 : r_rd_word;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               small behavioural word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [31:0] C_BASE = 32'h0100_0000;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [31:0] mem_data_out;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ready        (i_ready),
        .i_rdata        (i_rdata),
        .i_err          (i_err),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_size         (d_size),
        .d_unsigned     (d_unsigned),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ready        (d_ready),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_read_write (mem_read_write),
        .mem_data_out   (mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory: combinational read, posedge word write
    logic [31:0] mem [0:255];
    logic [31:0] w_off;
    logic [7:0]  w_idx;
    logic        load_en = 1'b0;
    logic [7:0]  load_idx = 8'd0;
    logic [31:0] load_val = 32'd0;
    int          wr_cnt = 0;
    int          both_ready_cnt = 0;

    assign w_off        = mem_address - C_BASE;
    assign w_idx        = w_off[9:2];
    assign mem_data_out = mem[w_idx];

    always @(posedge clock) begin
        if (load_en)             mem[load_idx] <= load_val;
        else if (mem_read_write) mem[w_idx]    <= mem_data_in;
    end

    always @(posedge clock) if (mem_read_write === 1'b1) wr_cnt++;
    always @(negedge clock) if (i_ready && d_ready) both_ready_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clock);
        load_en = 1'b1; load_idx = idx; load_val = val;
        @(posedge clock);
        #1 load_en = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clock);
        d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
        d_addr = addr; d_wdata = wdata;
        lat = 0; rdata = 32'hxxxx_xxxx; err = 1'bx;
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (d_ready) begin
                lat = k; rdata = d_rdata; err = d_err;
                break;
            end
        end
        d_req = 1'b0;
    endtask

    task automatic fetch_txn(input logic [31:0] addr,
                             output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clock);
        i_req = 1'b1; i_addr = addr;
        lat = 0; rdata = 32'hxxxx_xxxx; err = 1'bx;
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (i_ready) begin
                lat = k; rdata = i_rdata; err = i_err;
                break;
            end
        end
        i_req = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          wr_before;
    int          got;
    logic [3:0]  seq;
    logic [31:0] c_rd;
    logic [31:0] c_ird;

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0;
        #1;
        check("rst_i_ready", {31'd0, i_ready}, 32'd0);
        check("rst_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_errs", {30'd0, i_err, d_err}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);
        check("rst_mem_addr", mem_address, C_BASE);
        check("rst_mem_din", mem_data_in, 32'd0);

        preload(8'd4, 32'h8899_AABB);
        preload(8'd5, 32'hDEAD_BEEF);
        preload(8'd6, 32'h1122_3344);
        @(negedge clock) reset = 1'b0;

        // Word load
        data_txn(1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'd0, lat, rd, er);
        check("ldw_lat", lat, 32'd2);
        check("ldw_data", rd, 32'h8899_AABB);
        check("ldw_err", {31'd0, er}, 32'd0);

        // Byte store into lane 1
        wr_before = wr_cnt;
        data_txn(1'b1, 2'd0, 1'b0, 32'h0100_0011, 32'hFFFF_FF5A, lat, rd, er);
        check("stb_lat", lat, 32'd3);
        check("stb_rdata", rd, 32'd0);
        check("stb_err", {31'd0, er}, 32'd0);
        check("stb_writes", wr_cnt - wr_before, 32'd1);
        check("stb_mem", mem[4], 32'h8899_5ABB);

        // Byte and half loads with extension
        data_txn(1'b0, 2'd0, 1'b0, 32'h0100_0013, 32'd0, lat, rd, er);
        check("ldb_signed", rd, 32'hFFFF_FF88);
        data_txn(1'b0, 2'd0, 1'b1, 32'h0100_0013, 32'd0, lat, rd, er);
        check("ldb_unsigned", rd, 32'h0000_0088);
        data_txn(1'b0, 2'd1, 1'b0, 32'h0100_0012, 32'd0, lat, rd, er);
        check("ldh_signed", rd, 32'hFFFF_8899);
        data_txn(1'b0, 2'd1, 1'b1, 32'h0100_0010, 32'd0, lat, rd, er);
        check("ldh_unsigned", rd, 32'h0000_5ABB);

        // Half store into upper half
        data_txn(1'b1, 2'd1, 1'b0, 32'h0100_0012, 32'hABCD_1234, lat, rd, er);
        check("sth_lat", lat, 32'd3);
        check("sth_mem", mem[4], 32'h1234_5ABB);

        // Fetch
        fetch_txn(32'h0100_0014, lat, rd, er);
        check("fetch_lat", lat, 32'd2);
        check("fetch_data", rd, 32'hDEAD_BEEF);
        check("fetch_err", {31'd0, er}, 32'd0);

        // Error cases: one-cycle response, no memory write
        wr_before = wr_cnt;
        data_txn(1'b0, 2'd1, 1'b0, 32'h0100_0001, 32'd0, lat, rd, er);
        check("err_half_lat", lat, 32'd1);
        check("err_half_err", {31'd0, er}, 32'd1);
        check("err_half_rdata", rd, 32'd0);
        data_txn(1'b0, 2'd2, 1'b0, 32'h0110_0000, 32'd0, lat, rd, er);
        check("err_range_lat", lat, 32'd1);
        check("err_range_err", {31'd0, er}, 32'd1);
        fetch_txn(32'h0100_0002, lat, rd, er);
        check("err_fetch_lat", lat, 32'd1);
        check("err_fetch_err", {31'd0, er}, 32'd1);
        check("err_fetch_rdata", rd, 32'd0);
        data_txn(1'b0, 2'd3, 1'b0, 32'h0100_0000, 32'd0, lat, rd, er);
        check("err_size3", {31'd0, er}, 32'd1);
        data_txn(1'b1, 2'd2, 1'b0, 32'h0100_0011, 32'h0BAD_0BAD, lat, rd, er);
        check("err_store_err", {31'd0, er}, 32'd1);
        check("err_no_writes", wr_cnt - wr_before, 32'd0);
        data_txn(1'b0, 2'd2, 1'b0, 32'h0100_00FC, 32'd0, lat, rd, er);
        check("last_word_ok", {31'd0, er}, 32'd0);

        // Contention from reset: I, D, I, D
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h0100_0014;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h0100_0010;
        got = 0; seq = 4'd0; c_rd = 32'd0; c_ird = 32'd0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(posedge clock);
            #1;
            if (i_ready) begin seq = {seq[2:0], 1'b0}; got++; c_ird = i_rdata; end
            if (d_ready) begin seq = {seq[2:0], 1'b1}; got++; c_rd = d_rdata; end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("rr_count", got, 32'd4);
        check("rr_order", {28'd0, seq}, 32'h0000_0005);
        check("rr_i_data", c_ird, 32'hDEAD_BEEF);
        check("rr_d_data", c_rd, 32'h1234_5ABB);
        check("never_two_ready", both_ready_cnt, 32'd0);

        // Reset during WRITE must abandon the store
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h0100_0018;
        d_wdata = 32'hCAFE_F00D;
        @(posedge clock);
        @(posedge clock);
        #2;
        check("mid_in_write", {31'd0, mem_read_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rw_drop", {31'd0, mem_read_write}, 32'd0);
        check("mid_addr", mem_address, C_BASE);
        check("mid_din", mem_data_in, 32'd0);
        check("mid_ready", {30'd0, i_ready, d_ready}, 32'd0);
        d_req = 1'b0;
        @(posedge clock);
        #1;
        check("mid_mem_kept", mem[6], 32'h1122_3344);
        @(negedge clock) reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_no_resp", {30'd0, i_ready, d_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
